// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: default sizing and helper functions for the elastic register pipeline.
package reg_pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 3;

   // Width of the occupancy count; at least one bit even for a single stage.
   function automatic int occ_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid+data register of the elastic pipeline.
// clear drops the valid bit without touching data; data changes only on load.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             vin,
   input  logic [WIDTH-1:0] din,
   output logic             vout,
   output logic [WIDTH-1:0] dout
);

   // Reset wins over clear, clear wins over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         vout <= 1'b0;
         dout <= RESET_VAL;
      end else if (clear) begin
         vout <= 1'b0;
      end else if (load) begin
         vout <= vin;
         dout <= din;
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage elastic register pipeline with valid/ready handshake,
// bubble collapsing and synchronous flush.
// Optional feature macro: REG_PIPE_OCC_EN adds the occ (occupied-stage count) port.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter int               DEPTH     = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            din,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            dout
`ifdef REG_PIPE_OCC_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occ
`endif
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] d [DEPTH];

   // Ready ripples from the output back to the input; an empty stage is always ready.
   always_comb begin
      rdy[DEPTH-1] = !v[DEPTH-1] || out_ready;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         rdy[k] = !v[k] || rdy[k+1];
      end
   end

   assign in_ready  = rdy[0] && !flush;
   assign out_valid = v[DEPTH-1];
   assign dout      = d[DEPTH-1];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             stage_vin;
      logic [WIDTH-1:0] stage_din;

      if (k == 0) begin : g_head
         assign stage_vin = in_valid && in_ready;
         assign stage_din = din;
      end else begin : g_body
         assign stage_vin = v[k-1];
         assign stage_din = d[k-1];
      end

      reg_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .clear (flush),
         .load  (rdy[k]),
         .vin   (stage_vin),
         .din   (stage_din),
         .vout  (v[k]),
         .dout  (d[k])
      );
   end

`ifdef REG_PIPE_OCC_EN
   localparam int OCC_W = occ_width(DEPTH);

   // Popcount of the stage valids; exact every cycle since it reads the registers directly.
   always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ = occ + OCC_W'(v[k]);
      end
   end
`endif

endmodule
